// File: rtl/ram_sdp_be.sv
// Simple dual-port RAM with byte enables, a read-valid strobe and a zero-fill clear engine.
// Define RAM_OUT_REG_EN to add an output register stage (read latency 2 instead of 1).
module ram_sdp_be #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2048,
    parameter int RDW_MODE   = 0,
    parameter logic [DATA_WIDTH-1:0] CLR_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr_req,
    output logic                    busy,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid
);

    localparam int          BYTES   = DATA_WIDTH / 8;
    localparam int          MW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned DEPTH_U = DEPTH;

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t                  state;
    logic [MW-1:0]           clr_cnt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    wr_in_range, rd_in_range;
    logic                    wr_ok, rd_ok;
    logic [MW-1:0]           wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    s1_valid;
    logic [DATA_WIDTH-1:0]   s1_data;

    // Strobe semantics, no back-pressure: a port request is taken in any cycle
    // with busy=0; every taken read yields exactly one rd_valid pulse later.
    assign wr_in_range = 32'(wr_addr) < DEPTH_U;
    assign rd_in_range = 32'(rd_addr) < DEPTH_U;
    assign wr_idx      = wr_addr[MW-1:0];
    assign rd_idx      = rd_addr[MW-1:0];
    assign wr_ok       = wr_en && !busy && wr_in_range;
    assign rd_ok       = rd_en && !busy;

    // busy is the registered image of state==S_CLEAR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_CLEAR;
            clr_cnt <= '0;
            busy    <= 1'b1;
        end else begin
            case (state)
                S_CLEAR: begin
                    if (clr_cnt == MW'(DEPTH - 1)) begin
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                default: begin
                    if (clr_req) begin
                        state   <= S_CLEAR;
                        busy    <= 1'b1;
                        clr_cnt <= '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (busy) begin
            mem[clr_cnt] <= CLR_VALUE;
        end else if (wr_ok) begin
            for (int i = 0; i < BYTES; i++) begin
                if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // Bypass merge only matters for in-range collisions; out-of-range reads return 0.
    always_comb begin
        rd_word = mem[rd_idx];
        if (!rd_in_range) begin
            rd_word = '0;
        end else if (RDW_MODE != 0 && wr_ok && wr_idx == rd_idx) begin
            for (int i = 0; i < BYTES; i++) begin
                if (wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_ok;
            if (rd_ok) s1_data <= rd_word;
        end
    end

`ifdef RAM_OUT_REG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= s1_valid;
            if (s1_valid) rd_data <= s1_data;
        end
    end
`else
    assign rd_valid = s1_valid;
    assign rd_data  = s1_data;
`endif

endmodule
